video_timing_gen: RTL



---
 rtl/video_timing_pkg.sv | 32 +++
 rtl/video_timing_gen_if.sv | 27 ++
 rtl/video_timing_gen_sig_delay.sv | 36 +++
 rtl/video_timing_gen.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared raster timing types, stock video modes and a total-length helper.
package video_timing_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } axis_t;

    typedef struct packed {
        axis_t h;
        axis_t v;
    } timing_t;

    // Standard 640x480@60 (25.175 MHz pixel clock)
    localparam timing_t VGA_640X480 = '{
        h: '{active: 640, fp: 16, sync: 96, bp: 48},
        v: '{active: 480, fp: 10, sync: 2,  bp: 33}
    };

    // GameBoy 160x144 canvas scaled 4x to 640x576
    localparam timing_t GB_160X144_X4 = '{
        h: '{active: 640, fp: 16, sync: 64, bp: 80},
        v: '{active: 576, fp: 1,  sync: 3,  bp: 20}
    };

    function automatic int axis_total(axis_t a);
        return a.active + a.fp + a.sync + a.bp;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Timing/coordinate bundle between the raster generator and its consumers.
interface video_timing_gen_if #(
    parameter int CNT_W = 12
);
    logic             en;
    logic             pix_req;
    logic [CNT_W-1:0] pix_x;
    logic [CNT_W-1:0] pix_y;
    logic             frame_start;
    logic             line_start;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [7:0]       frame_cnt;

    modport master (
        input  en,
        output pix_req, pix_x, pix_y, frame_start, line_start,
        output hsync, vsync, de, frame_cnt
    );

    modport slave (
        output en,
        input  pix_req, pix_x, pix_y, frame_start, line_start,
        input  hsync, vsync, de, frame_cnt
    );
endinterface

// File: rtl/video_timing_gen_sig_delay.sv
// Fixed-depth shift register with a caller-supplied reset/idle value.
// DEPTH=0 is a plain wire.
module sig_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_bypass;
            assign unused_bypass = ^{clk, rst, rst_val};
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_reg [DEPTH];

            // Shift the bundle one stage per clock; reset loads the idle value everywhere
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) stage_reg[i] <= rst_val;
                end else begin
                    stage_reg[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
                end
            end

            assign dout = stage_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: counters, stage-0 coordinate/strobe register and
// a delay line that realigns hsync/vsync/de with returned pixel data.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_640X480.h.active,
    parameter int H_FP       = VGA_640X480.h.fp,
    parameter int H_SYNC     = VGA_640X480.h.sync,
    parameter int H_BP       = VGA_640X480.h.bp,
    parameter int V_ACTIVE   = VGA_640X480.v.active,
    parameter int V_FP       = VGA_640X480.v.fp,
    parameter int V_SYNC     = VGA_640X480.v.sync,
    parameter int V_BP       = VGA_640X480.v.bp,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int PIPE_DELAY = 2,
    parameter int CNT_W      = 12
) (
    input  logic              clk,
    input  logic              rst,
    video_timing_gen_if.master vt
);

    localparam axis_t H_AXIS  = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam axis_t V_AXIS  = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int    H_TOTAL = axis_total(H_AXIS);
    localparam int    V_TOTAL = axis_total(V_AXIS);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if ((H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_bad_width
            $error("video_timing_gen: CNT_W=%0d cannot hold H_TOTAL=%0d / V_TOTAL=%0d",
                   CNT_W, H_TOTAL, V_TOTAL);
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_delay
            $error("video_timing_gen: PIPE_DELAY=%0d outside 0..15", PIPE_DELAY);
        end
    endgenerate

    logic [CNT_W-1:0] h_cnt_reg;
    logic [CNT_W-1:0] v_cnt_reg;
    logic [7:0]       frame_cnt_reg;

    logic             act;
    logic             hs_raw;
    logic             vs_raw;

    logic             pix_req_reg;
    logic             frame_start_reg;
    logic             line_start_reg;
    logic [CNT_W-1:0] pix_x_reg;
    logic [CNT_W-1:0] pix_y_reg;
    logic             hs_reg;
    logic             vs_reg;

    logic [2:0]       dly_bus;

    // Raster counters: advance while enabled, park at the origin otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_reg     <= '0;
            v_cnt_reg     <= '0;
            frame_cnt_reg <= '0;
        end else if (!vt.en) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (h_cnt_reg == H_LAST) begin
            h_cnt_reg <= '0;
            if (v_cnt_reg == V_LAST) begin
                v_cnt_reg     <= '0;
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end else begin
                v_cnt_reg <= v_cnt_reg + CNT_W'(1);
            end
        end else begin
            h_cnt_reg <= h_cnt_reg + CNT_W'(1);
        end
    end

    // Region decode from the current counter position
    always_comb begin
        act    = (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
        hs_raw = (h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END);
        vs_raw = (v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END);
    end

    // Stage 0: coordinates and strobes one cycle after the counter state; idle when disabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_req_reg     <= 1'b0;
            frame_start_reg <= 1'b0;
            line_start_reg  <= 1'b0;
            pix_x_reg       <= '0;
            pix_y_reg       <= '0;
            hs_reg          <= ~HS_POL;
            vs_reg          <= ~VS_POL;
        end else begin
            pix_x_reg <= h_cnt_reg;
            pix_y_reg <= v_cnt_reg;
            if (vt.en) begin
                pix_req_reg     <= act;
                frame_start_reg <= act && (h_cnt_reg == '0) && (v_cnt_reg == '0);
                line_start_reg  <= act && (h_cnt_reg == '0);
                hs_reg          <= hs_raw ? HS_POL : ~HS_POL;
                vs_reg          <= vs_raw ? VS_POL : ~VS_POL;
            end else begin
                pix_req_reg     <= 1'b0;
                frame_start_reg <= 1'b0;
                line_start_reg  <= 1'b0;
                hs_reg          <= ~HS_POL;
                vs_reg          <= ~VS_POL;
            end
        end
    end

    // Sync/DE realignment: the delay line keeps shifting, so a disabled raster drains to idle
    sig_delay #(
        .DEPTH (PIPE_DELAY),
        .WIDTH (3)
    ) u_sync_delay (
        .clk     (clk),
        .rst     (rst),
        .rst_val ({~HS_POL, ~VS_POL, 1'b0}),
        .din     ({hs_reg, vs_reg, pix_req_reg}),
        .dout    (dly_bus)
    );

    assign vt.pix_req     = pix_req_reg;
    assign vt.pix_x       = pix_x_reg;
    assign vt.pix_y       = pix_y_reg;
    assign vt.frame_start = frame_start_reg;
    assign vt.line_start  = line_start_reg;
    assign vt.hsync       = dly_bus[2];
    assign vt.vsync       = dly_bus[1];
    assign vt.de          = dly_bus[0];
    assign vt.frame_cnt   = frame_cnt_reg;

endmodule
